// File: rtl/mips_multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mips_multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       error;

  modport master (
    input  op, funct, zero, memready,
    output pcen, memread, memwrite, irwrite, regwrite, iord, alusrca,
           alusrcb, pcsrc, regdst, memtoreg, alucontrol, state, error
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, memread, memwrite, irwrite, regwrite, iord, alusrca,
           alusrcb, pcsrc, regdst, memtoreg, alucontrol, state, error
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with memory-ready stalls,
// a bounded wait timeout and a sticky trap state for timeouts and illegal opcodes.
module mips_multicycle_controller #(
  parameter int unsigned maxwait = 15
) (
  input logic                        clk,
  input logic                        reset,
  mips_multicycle_controller_if.master bus
);

  localparam int unsigned cw = $clog2(maxwait + 1);

  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_jal   = 6'b000011;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    JAL     = 4'd12,
    ERROR   = 4'd15
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [cw-1:0] wait_cnt;
  logic          err;
  logic          funct_ok;
  logic [2:0]    funct_alu;
  logic          wait_state;
  logic          timeout;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (bus.funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default: begin
        funct_alu = 3'b010;
        funct_ok  = 1'b0;
      end
    endcase
  end

  // The wait counter only ever runs while holding in one memory state, so the
  // timeout compares against maxwait-1: the maxwait-th low cycle traps.
  assign wait_state = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
  assign timeout    = wait_state && !bus.memready && (wait_cnt == cw'(maxwait - 1));

  always_comb begin
    nxt = st;
    case (st)
      FETCH:   nxt = bus.memready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          op_lw, op_sw: nxt = MEMADR;
          op_rtype:     nxt = EXECUTE;
          op_beq:       nxt = BRANCH;
          op_addi:      nxt = ADDIEX;
          op_j:         nxt = JUMP;
          op_jal:       nxt = JAL;
          default:      nxt = ERROR;
        endcase
      end
      MEMADR: begin
        if (bus.op == op_lw)      nxt = MEMRD;
        else if (bus.op == op_sw) nxt = MEMWR;
        else                      nxt = ERROR;
      end
      MEMRD:   nxt = bus.memready ? MEMWB : MEMRD;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = bus.memready ? FETCH : MEMWR;
      EXECUTE: nxt = funct_ok ? ALUWB : ERROR;
      ALUWB:   nxt = FETCH;
      BRANCH:  nxt = FETCH;
      ADDIEX:  nxt = ADDIWB;
      ADDIWB:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      JAL:     nxt = FETCH;
      ERROR:   nxt = ERROR;
      default: nxt = ERROR;
    endcase
    if (timeout) nxt = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      st  <= nxt;
      err <= err || (nxt == ERROR);
      if (nxt != st)
        wait_cnt <= '0;
      else if (wait_state && !bus.memready)
        wait_cnt <= wait_cnt + cw'(1);
    end
  end

  always_comb begin
    bus.pcen       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.regdst     = 2'b00;
    bus.memtoreg   = 2'b00;
    bus.alucontrol = 3'b010;
    case (st)
      FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.memready;
        bus.pcen    = bus.memready;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 2'b01;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
      end
      ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 2'b01;
      end
      BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = 3'b110;
        bus.pcsrc      = 2'b01;
        bus.pcen       = bus.zero;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB:  bus.regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
      end
      JAL: begin
        bus.pcsrc    = 2'b10;
        bus.pcen     = 1'b1;
        bus.regwrite = 1'b1;
        bus.regdst   = 2'b10;
        bus.memtoreg = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.state = st;
  assign bus.error = err;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed vector table, hand-written stall/timeout
// sequences and randomized traffic checked against an instruction-path reference model.
module tb_mips_multicycle_controller;

  localparam int unsigned MAXWAIT = 15;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JALO = 6'b000011;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [5:0] SUB  = 6'b100010;

  typedef struct packed {
    logic       pcen, memread, memwrite, irwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       error;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, mr;
    logic [3:0] st;
    logic       pcen, irw, rw;
    logic [1:0] rd, mtr, pcs;
    logic [2:0] alu;
    logic       err;
  } vec_t;

  logic clk;
  logic reset;
  mips_multicycle_controller_if bus();

  mips_multicycle_controller #(.maxwait(MAXWAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the instruction's remaining state path plus a wait count.
  int m_state = 0;
  int m_wait  = 0;
  int path[$];

  function automatic logic [3:0] alu_of(input logic [5:0] f, output logic ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  function automatic ctl_t spec_ctl(input int st, input logic [5:0] f, input logic z, input logic mr);
    ctl_t c;
    logic ok;
    c = '0;
    c.alucontrol = 3'b010;
    c.state = st[3:0];
    case (st)
      0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
      1:  c.alusrcb = 2'b11;
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  begin c.memread = 1; c.iord = 1; end
      4:  begin c.regwrite = 1; c.memtoreg = 2'b01; end
      5:  begin c.memwrite = 1; c.iord = 1; end
      6:  begin c.alusrca = 1; c.alucontrol = alu_of(f, ok); end
      7:  begin c.regwrite = 1; c.regdst = 2'b01; end
      8:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      10: c.regwrite = 1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1; end
      12: begin c.pcsrc = 2'b10; c.pcen = 1; c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      15: c.error = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = {bus.pcen, bus.memread, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.alusrca,
         bus.alusrcb, bus.pcsrc, bus.regdst, bus.memtoreg, bus.alucontrol, bus.state, bus.error};
    return c;
  endfunction

  task automatic load_path(input logic [5:0] o, input logic [5:0] f);
    logic ok;
    logic [2:0] unused_alu;
    path.delete();
    path.push_back(1);
    case (o)
      LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
      SW:   begin path.push_back(2); path.push_back(5); end
      RT:   begin
        unused_alu = alu_of(f, ok);
        path.push_back(6);
        path.push_back(ok ? 7 : 15);
      end
      BEQ:  path.push_back(8);
      ADDI: begin path.push_back(9); path.push_back(10); end
      J:    path.push_back(11);
      JALO: path.push_back(12);
      default: path.push_back(15);
    endcase
  endtask

  task automatic model_reset();
    m_state = 0;
    m_wait = 0;
    path.delete();
  endtask

  task automatic model_clock(input logic mr);
    if (m_state == 15) return;
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
      m_wait++;
      if (m_wait >= int'(MAXWAIT)) begin
        m_state = 15;
        path.delete();
      end
      return;
    end
    m_wait = 0;
    if (m_state == 0) load_path(bus.op, bus.funct);
    m_state = (path.size() == 0) ? 0 : path.pop_front();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are compared 1 time unit later.
  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr);
    ctl_t e;
    ctl_t a;
    @(negedge clk);
    reset = r;
    bus.op = o;
    bus.funct = f;
    bus.zero = z;
    bus.memready = mr;
    #1;
    if (r) model_reset();
    e = spec_ctl(m_state, f, z, mr);
    a = dut_ctl();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL model st=%0d: got %h expected %h (t=%0t)", m_state, a, e, $time);
    end
  endtask

  task automatic tick(input logic r, input logic mr);
    @(posedge clk);
    if (!r) model_clock(mr);
  endtask

  vec_t tbl[$];
  logic [5:0] vf[5];
  logic [5:0] rop, rfn;
  logic rr, rz, rmr, stall;
  int err_hold;

  initial begin
    reset = 1'b1;
    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.memready = 1'b1;

    //            rst op    funct zero mr  st    pcen irw rw rd     mtr    pcs    alu     err
    tbl.push_back({1'b1, LW,  6'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, LW,  6'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, LW,  6'd0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, LW,  6'd0, 1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, LW,  6'd0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, LW,  6'd0, 1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, RT,  SUB,  1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, RT,  SUB,  1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, RT,  SUB,  1'b0, 1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b110, 1'b0});
    tbl.push_back({1'b0, RT,  SUB,  1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b110, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b110, 1'b0});
    tbl.push_back({1'b0, JALO,6'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, JALO,6'd0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, JALO,6'd0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 3'b010, 1'b0});
    tbl.push_back({1'b0, BAD, 6'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BAD, 6'd0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0});
    tbl.push_back({1'b0, BAD, 6'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b1});
    tbl.push_back({1'b0, BAD, 6'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b1});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].mr);
      chk($sformatf("table[%0d]", i),
          int'({bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.regdst, bus.memtoreg,
                bus.pcsrc, bus.alucontrol, bus.error}),
          int'({tbl[i].st, tbl[i].pcen, tbl[i].irw, tbl[i].rw, tbl[i].rd, tbl[i].mtr,
                tbl[i].pcs, tbl[i].alu, tbl[i].err}));
      tick(tbl[i].rst, tbl[i].mr);
    end

    // FETCH stalled three cycles, then released.
    drive(1'b1, LW, 6'd0, 1'b0, 1'b0); tick(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, LW, 6'd0, 1'b0, 1'b0);
      chk("fetch_stall_state", int'(bus.state), 0);
      chk("fetch_stall_en", int'({bus.irwrite, bus.pcen, bus.error}), 0);
      tick(1'b0, 1'b0);
    end
    drive(1'b0, LW, 6'd0, 1'b0, 1'b1);
    chk("fetch_release_en", int'({bus.irwrite, bus.pcen}), 3);
    tick(1'b0, 1'b1);
    drive(1'b0, LW, 6'd0, 1'b0, 1'b1);
    chk("fetch_release_decode", int'(bus.state), 1);
    tick(1'b0, 1'b1);

    // MEMRD: memready arriving on the 15th cycle still advances normally.
    drive(1'b0, LW, 6'd0, 1'b0, 1'b1); tick(1'b0, 1'b1);
    for (int k = 0; k < int'(MAXWAIT) - 1; k++) begin
      drive(1'b0, LW, 6'd0, 1'b0, 1'b0);
      chk("memrd_wait_state", int'({bus.state, bus.memread}), 7);
      tick(1'b0, 1'b0);
    end
    drive(1'b0, LW, 6'd0, 1'b0, 1'b1); tick(1'b0, 1'b1);
    drive(1'b0, LW, 6'd0, 1'b0, 1'b1);
    chk("memrd_last_cycle_ready", int'(bus.state), 4);
    tick(1'b0, 1'b1);

    // MEMRD: 15 low cycles trap, then asynchronous reset recovers.
    drive(1'b1, LW, 6'd0, 1'b0, 1'b1); tick(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin drive(1'b0, LW, 6'd0, 1'b0, 1'b1); tick(1'b0, 1'b1); end
    for (int k = 0; k < int'(MAXWAIT); k++) begin
      drive(1'b0, LW, 6'd0, 1'b0, 1'b0);
      chk("memrd_timeout_wait", int'(bus.state), 3);
      tick(1'b0, 1'b0);
    end
    drive(1'b0, LW, 6'd0, 1'b0, 1'b0);
    chk("timeout_error", int'({bus.state, bus.error}), 31);
    chk("timeout_enables", int'({bus.pcen, bus.memread, bus.memwrite, bus.irwrite, bus.regwrite}), 0);
    drive(1'b1, LW, 6'd0, 1'b0, 1'b0);
    chk("async_reset_clear", int'({bus.state, bus.error}), 0);
    tick(1'b1, 1'b0);

    // Randomized traffic against the reference model.
    vf = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    stall = 1'b0;
    err_hold = 0;
    rop = LW;
    rfn = 6'd0;
    for (int n = 0; n < 4000; n++) begin
      rr = ($urandom_range(0, 299) == 0) || (m_state == 15 && err_hold >= 3);
      if (m_state == 0) begin
        case ($urandom_range(0, 7))
          0: rop = LW;
          1: rop = SW;
          2: rop = RT;
          3: rop = BEQ;
          4: rop = ADDI;
          5: rop = J;
          6: rop = JALO;
          default: rop = 6'($urandom);
        endcase
        rfn = ($urandom_range(0, 4) != 0) ? vf[$urandom_range(0, 4)] : 6'($urandom);
        stall = ($urandom_range(0, 7) == 0);
      end
      rmr = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 8);
      rz = 1'($urandom_range(0, 1));
      drive(rr, rop, rfn, rz, rmr);
      tick(rr, rmr);
      err_hold = (m_state == 15) ? err_hold + 1 : 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Moore-style control FSM that sequences a multicycle MIPS datapath (shared instruction/data memory, IR, ALUOut, single ALU) through fetch, decode, execute, memory and writeback steps. It sits beside the multicycle datapath inside the CPU, replacing the single-cycle combinational controller. It stalls on a memory ready handshake and traps to a sticky error state on memory timeout or an illegal opcode.

## Interface
- maxwait, 15: consecutive memready-low cycles tolerated in one memory wait state before trapping (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH, clears wait counter and error
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- memready  in  1  memory completes current access this cycle
- pcen  out  1  PC register enable
- memread, memwrite  out  1  memory strobes
- irwrite  out  1  IR load enable
- regwrite  out  1  register file write enable
- iord  out  1  address mux: 0=PC, 1=ALUOut
- alusrca  out  1  0=PC, 1=regA
- alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- regdst  out  2  00=rt, 01=rd, 10=r31
- memtoreg  out  2  00=ALUOut, 01=mem data, 10=PC
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- state  out  4  current state encoding (debug)
- error  out  1  sticky trap flag

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, ERROR 15; 13/14 unreachable, go to ERROR.
- Every output is 0 unless listed; alucontrol defaults 010.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00; irwrite=pcen=memready. If memready, go to DECODE; else hold.
- DECODE: alusrcb=11 (branch target into ALUOut). By op: 100011 lw / 101011 sw → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP; 000011 → JAL; other → ERROR.
- MEMADR: alusrca=1, alusrcb=10. lw → MEMRD, sw → MEMWR.
- MEMRD: memread=1, iord=1; on memready → MEMWB, else hold.
- MEMWB: regwrite=1, regdst=00, memtoreg=01 → FETCH.
- MEMWR: memwrite=1, iord=1; on memready → FETCH, else hold.
- EXECUTE: alusrca=1, alusrcb=00; alucontrol by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other → 010 and next state ERROR; valid → ALUWB.
- ALUWB: regwrite=1, regdst=01, memtoreg=00 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero → FETCH.
- ADDIEX: alusrca=1, alusrcb=10 → ADDIWB. ADDIWB: regwrite=1, regdst=00, memtoreg=00 → FETCH.
- JUMP: pcsrc=10, pcen=1 → FETCH.
- JAL: pcsrc=10, pcen=1, regwrite=1, regdst=10, memtoreg=10 (PC already holds PC+4) → FETCH.
- ERROR: all strobes/enables 0, error=1; exits only via reset.

## Timing
- Reset (async): state=0, wait counter=0, error=0; combinationally memread=1, alusrcb=01, alucontrol=010, irwrite=pcen=memready, others 0.
- Outputs are combinational decodes of state (plus funct, zero, memready as above); state updates on rising clk.
- Latency with memready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3 cycles.
- Wait counter ($clog2(maxwait+1) bits) cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle there with memready=0. Edge ending the maxwait-th consecutive low cycle → ERROR instead of holding. memready=1 on that same cycle wins (normal advance).
- memread/memwrite stay asserted throughout waits; no strobe ever spans two different states.
- Reset asserted mid-instruction aborts it immediately; no partial writeback.

## Test plan
- Reset, memready=1, op=100011: state 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=01, regdst=00.
- op=000000 funct=100010: EXECUTE alucontrol=110; ALUWB regwrite=1, regdst=01; back to FETCH after 4 cycles.
- op=000100: zero=1 → pcen=1, pcsrc=01 in BRANCH; repeat with zero=0 → pcen=0.
- FETCH with memready low 3 cycles, then high: state stays 0, irwrite=pcen=0 for 3 cycles, then irwrite=pcen=1, DECODE next; error=0.
- MEMRD with memready low 15 cycles (maxwait=15): state=15, error=1, all enables 0; async reset mid-ERROR → state 0, error 0 without clock.
- op=111111 → ERROR after DECODE; op=000011 → JAL: pcen=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10.
